// File: rtl/pipe_pkg.sv
// Shared constants for the valid/ready pipeline stage register: occupancy states,
// default field widths, exception vector and sideband payload field offsets.
package pipe_pkg;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccTwo   = 2'd2
    } occ_e;

    localparam int unsigned PC_W_DEF    = 32;
    localparam int unsigned INSTR_W     = 32;
    localparam int unsigned DATA_W_DEF  = 130;

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;

    // Sideband payload layout inside DATA_W (LSB offsets)
    localparam int unsigned SB_READ_DATA_LSB = 0;
    localparam int unsigned SB_ALU_RES_LSB   = 32;
    localparam int unsigned SB_MD_RES_LSB    = 64;
    localparam int unsigned SB_R_DATA_LSB    = 96;
    localparam int unsigned SB_CMP_FLAG_BIT  = 128;
    localparam int unsigned SB_LL_BIT        = 129;

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of the stage (valid, pc, instr, data) with load, clear,
// exception set_pc and invalidate controls; priority set_pc > clear > load > invalidate.
module pipe_entry #(
    parameter int unsigned DATA_W = 130,
    parameter int unsigned PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              set_pc_i,
    input  logic              invalidate_i,
    input  logic [PC_W-1:0]   set_pc_val_i,
    input  logic [PC_W-1:0]   ld_pc_i,
    input  logic [31:0]       ld_instr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              valid_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [31:0]       instr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        data_d  = data_q;
        if (set_pc_i) begin
            valid_d = 1'b0;
            pc_d    = set_pc_val_i;
            instr_d = '0;
            data_d  = '0;
        end else if (clear_i) begin
            valid_d = 1'b0;
            pc_d    = '0;
            instr_d = '0;
            data_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = ld_pc_i;
            instr_d = ld_instr_i;
            data_d  = ld_data_i;
        end else if (invalidate_i) begin
            // Fields are kept so out_* holds the last head value while idle
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with a head entry and a skid entry, flush and exception redirect.
// Optional backpressure counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned     DATA_W     = DATA_W_DEF,
    parameter int unsigned     PC_W       = PC_W_DEF,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(EXC_VECTOR_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [31:0]       out_instr,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              exc_req,
    output logic [1:0]        occ,
    output logic [31:0]       stall_cnt
);

    logic              head_valid, skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [31:0]       skid_instr;
    logic [DATA_W-1:0] skid_data;

    logic head_load, head_from_skid, head_inval, head_clear, head_set_pc;
    logic skid_load, skid_inval, skid_clear;
    logic push, pop;
    occ_e state;

    // Occupancy is the state; it lives in the two entry valid flops
    assign occ      = {1'b0, head_valid} + {1'b0, skid_valid};
    assign state    = occ_e'(occ);
    assign in_ready = !skid_valid;
    assign push     = in_valid && in_ready;
    assign pop      = head_valid && out_ready;

    always_comb begin
        head_load      = 1'b0;
        head_from_skid = 1'b0;
        head_inval     = 1'b0;
        head_clear     = 1'b0;
        head_set_pc    = 1'b0;
        skid_load      = 1'b0;
        skid_inval     = 1'b0;
        skid_clear     = 1'b0;
        if (exc_req) begin
            head_set_pc = 1'b1;
            skid_clear  = 1'b1;
        end else if (flush) begin
            head_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            unique case (state)
                OccEmpty: begin
                    if (push) head_load = 1'b1;
                end
                OccOne: begin
                    if (push && pop) begin
                        head_load = 1'b1;
                    end else if (push) begin
                        skid_load = 1'b1;
                    end else if (pop) begin
                        head_inval = 1'b1;
                    end
                end
                OccTwo: begin
                    if (pop) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_inval     = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    pipe_entry #(
        .DATA_W(DATA_W),
        .PC_W  (PC_W)
    ) u_head (
        .clk         (clk),
        .reset       (reset),
        .load_i      (head_load),
        .clear_i     (head_clear),
        .set_pc_i    (head_set_pc),
        .invalidate_i(head_inval),
        .set_pc_val_i(EXC_VECTOR),
        .ld_pc_i     (head_from_skid ? skid_pc    : in_pc),
        .ld_instr_i  (head_from_skid ? skid_instr : in_instr),
        .ld_data_i   (head_from_skid ? skid_data  : in_data),
        .valid_o     (head_valid),
        .pc_o        (out_pc),
        .instr_o     (out_instr),
        .data_o      (out_data)
    );

    pipe_entry #(
        .DATA_W(DATA_W),
        .PC_W  (PC_W)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .load_i      (skid_load),
        .clear_i     (skid_clear),
        .set_pc_i    (1'b0),
        .invalidate_i(skid_inval),
        .set_pc_val_i('0),
        .ld_pc_i     (in_pc),
        .ld_instr_i  (in_instr),
        .ld_data_i   (in_data),
        .valid_o     (skid_valid),
        .pc_o        (skid_pc),
        .instr_o     (skid_instr),
        .data_o      (skid_data)
    );

    assign out_valid = head_valid;

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Only reset clears the counter; flush and exception redirect keep it
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_valid && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Table-driven bench for pipe_stage_reg plus a hand-written backpressure counter sequence.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 130;
    localparam int unsigned PC_W   = 32;

    localparam logic [31:0] AP = 32'h0000_3000, AI = 32'h2401_0001;
    localparam logic [31:0] BP = 32'h0000_3004, BI = 32'h2402_0002;
    localparam logic [31:0] CP = 32'h0000_3008, CI = 32'h2403_0003;
    localparam logic [31:0] DP = 32'h0000_300c, DI = 32'h2404_0004;
    localparam logic [31:0] EXC = 32'h0000_4180;
    localparam logic [63:0] DA = {AI, AP}, DB = {BI, BP}, DC = {CI, CP};

`ifdef PIPE_STALL_CNT_EN
    localparam logic [31:0] EXP_STALL = 32'd7;
`else
    localparam logic [31:0] EXP_STALL = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              reset, in_valid, in_ready, out_valid, out_ready, flush, exc_req;
    logic [PC_W-1:0]   in_pc, out_pc;
    logic [31:0]       in_instr, out_instr, stall_cnt;
    logic [DATA_W-1:0] in_data, out_data;
    logic [1:0]        occ;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .out_data (out_data),
        .flush    (flush),
        .exc_req  (exc_req),
        .occ      (occ),
        .stall_cnt(stall_cnt)
    );

    typedef struct packed {
        logic        rst, fl, exc, iv;
        logic [31:0] pc, instr;
        logic        ordy;
        logic        ov;
        logic [31:0] epc, einstr;
        logic [63:0] edata;
        logic [1:0]  eocc;
        logic        erdy;
    } vec_t;

    int errors = 0;
    int checks = 0;
    vec_t tbl[20];

    function automatic vec_t v(input logic rst, fl, exc, iv, input logic [31:0] pc, instr,
                               input logic ordy, ov, input logic [31:0] epc, einstr,
                               input logic [63:0] edata, input logic [1:0] eocc,
                               input logic erdy);
        vec_t r;
        r = '{rst, fl, exc, iv, pc, instr, ordy, ov, epc, einstr, edata, eocc, erdy};
        return r;
    endfunction

    task automatic chk(input string name, input logic [DATA_W-1:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at negedge, then sample 1 time unit after the following posedge
    task automatic step(input logic rst, fl, exc, iv, input logic [31:0] pc, instr,
                        input logic ordy);
        @(negedge clk);
        reset     = rst;
        flush     = fl;
        exc_req   = exc;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        in_data   = DATA_W'({instr, pc});
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; exc_req = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_instr = '0; in_data = '0; out_ready = 1'b0;

        // reset
        tbl[0]  = v(1,0,0,0, 0, 0, 0,  0, 0, 0, 0, 2'd0, 1);
        // back-to-back flow, occupancy stays 1
        tbl[1]  = v(0,0,0,1, AP,AI,1,  1, AP,AI,DA, 2'd1, 1);
        tbl[2]  = v(0,0,0,1, BP,BI,1,  1, BP,BI,DB, 2'd1, 1);
        tbl[3]  = v(0,0,0,1, CP,CI,1,  1, CP,CI,DC, 2'd1, 1);
        tbl[4]  = v(0,0,0,0, 0, 0, 1,  0, CP,CI,DC, 2'd0, 1);
        // backpressure fills skid; D offered while full is not taken
        tbl[5]  = v(0,0,0,1, AP,AI,0,  1, AP,AI,DA, 2'd1, 1);
        tbl[6]  = v(0,0,0,1, BP,BI,0,  1, AP,AI,DA, 2'd2, 0);
        tbl[7]  = v(0,0,0,1, DP,DI,0,  1, AP,AI,DA, 2'd2, 0);
        tbl[8]  = v(0,0,0,1, DP,DI,1,  1, BP,BI,DB, 2'd1, 1);
        tbl[9]  = v(0,0,0,0, 0, 0, 1,  0, BP,BI,DB, 2'd0, 1);
        // flush while full, simultaneous push dropped
        tbl[10] = v(0,0,0,1, AP,AI,0,  1, AP,AI,DA, 2'd1, 1);
        tbl[11] = v(0,0,0,1, BP,BI,0,  1, AP,AI,DA, 2'd2, 0);
        tbl[12] = v(0,1,0,1, CP,CI,1,  0, 0, 0, 0,  2'd0, 1);
        tbl[13] = v(0,0,0,0, 0, 0, 1,  0, 0, 0, 0,  2'd0, 1);
        // exception beats flush, push and pop
        tbl[14] = v(0,0,0,1, AP,AI,0,  1, AP,AI,DA, 2'd1, 1);
        tbl[15] = v(0,1,1,1, CP,CI,1,  0, EXC,0, 0, 2'd0, 1);
        tbl[16] = v(0,0,0,0, 0, 0, 1,  0, EXC,0, 0, 2'd0, 1);
        // reset while full with push pending
        tbl[17] = v(0,0,0,1, AP,AI,0,  1, AP,AI,DA, 2'd1, 1);
        tbl[18] = v(0,0,0,1, BP,BI,0,  1, AP,AI,DA, 2'd2, 0);
        tbl[19] = v(1,0,0,1, CP,CI,0,  0, 0, 0, 0,  2'd0, 1);

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].rst, tbl[i].fl, tbl[i].exc, tbl[i].iv, tbl[i].pc, tbl[i].instr,
                 tbl[i].ordy);
            chk($sformatf("row%0d out_valid", i), DATA_W'(out_valid), DATA_W'(tbl[i].ov));
            chk($sformatf("row%0d out_pc", i),    DATA_W'(out_pc),    DATA_W'(tbl[i].epc));
            chk($sformatf("row%0d out_instr", i), DATA_W'(out_instr), DATA_W'(tbl[i].einstr));
            chk($sformatf("row%0d out_data", i),  out_data,           DATA_W'(tbl[i].edata));
            chk($sformatf("row%0d occ", i),       DATA_W'(occ),       DATA_W'(tbl[i].eocc));
            chk($sformatf("row%0d in_ready", i),  DATA_W'(in_ready),  DATA_W'(tbl[i].erdy));
            if (i == 0) chk("reset stall_cnt", DATA_W'(stall_cnt), '0);
        end

        // Backpressure counter: 7 stalled cycles, kept across flush, cleared by reset
        step(1,0,0,0, 0, 0, 0);
        chk("stall after reset", DATA_W'(stall_cnt), '0);
        step(0,0,0,1, AP,AI,0);
        chk("stall first push", DATA_W'(stall_cnt), '0);
        for (int k = 0; k < 7; k++) step(0,0,0,0, 0, 0, 0);
        chk("stall held 7", DATA_W'(stall_cnt), DATA_W'(EXP_STALL));
        chk("stall head still valid", DATA_W'(out_valid), DATA_W'(1'b1));
        step(0,1,0,0, 0, 0, 1);
        chk("stall kept by flush", DATA_W'(stall_cnt), DATA_W'(EXP_STALL));
        chk("flush clears valid", DATA_W'(out_valid), '0);
        step(0,0,0,0, 0, 0, 0);
        step(0,0,0,0, 0, 0, 0);
        chk("stall idle no count", DATA_W'(stall_cnt), DATA_W'(EXP_STALL));
        step(1,0,0,0, 0, 0, 0);
        chk("stall cleared by reset", DATA_W'(stall_cnt), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
